// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// The clear FSM encoding, default sizes and write-port priority select live here.
package reg_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_t;

   localparam int DEF_ADDR_WIDTH    = 4;
   localparam int DEF_DATA_WIDTH    = 16;
   localparam int DEF_REG_FILE_SIZE = 16;
   localparam int DEF_NUM_RD        = 2;
   localparam int DEF_NUM_WR        = 2;

   // Widest write-port set the priority select can arbitrate.
   localparam int MAX_WR_PORTS = 8;

   // Highest-index asserted hit wins; -1 when no port hits.
   function automatic int prio_sel(input logic [MAX_WR_PORTS-1:0] hits);
      int sel;
      sel = -1;
      for (int k = 0; k < MAX_WR_PORTS; k++) begin
         if (hits[k]) sel = k;
      end
      return sel;
   endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write bit per register: reservation sets, write clears, flush zeroes all.
// A reservation in the same cycle as a write to that register keeps the bit set.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int REG_FILE_SIZE = DEF_REG_FILE_SIZE,
   parameter int NUM_RD        = DEF_NUM_RD
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         rsv_en_i,
   input  logic [ADDR_WIDTH-1:0]        rsv_addr_i,
   input  logic [REG_FILE_SIZE-1:0]     wr_clr_i,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] lk_addr_i,
   output logic [NUM_RD-1:0]            lk_pend_o
);

   localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH+1)'(REG_FILE_SIZE);

   logic [REG_FILE_SIZE-1:0] pend_q;
   logic [REG_FILE_SIZE-1:0] pend_d;

   always_comb begin
      pend_d = pend_q & ~wr_clr_i;
      if (rsv_en_i) pend_d[rsv_addr_i] = 1'b1;
      if (flush_i)  pend_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend_q <= '0;
      else      pend_q <= pend_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
      logic [ADDR_WIDTH-1:0] a;
      assign a            = lk_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign lk_pend_o[i] = ({1'b0, a} < SIZE_L) ? pend_q[a] : 1'b0;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending-bit scoreboard and sequential clear FSM.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int REG_FILE_SIZE = DEF_REG_FILE_SIZE,
   parameter int NUM_RD        = DEF_NUM_RD,
   parameter int NUM_WR        = DEF_NUM_WR,
   parameter int ZERO_REG      = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_req,
   output logic                         busy,
   output logic                         dbg_state,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] reg_r_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] reg_r_data,
   output logic [NUM_RD-1:0]            reg_r_pend,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] reg_w_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] reg_w_data,
   input  logic [NUM_WR-1:0]            reg_w_en,
   input  logic [ADDR_WIDTH-1:0]        rsv_addr,
   input  logic                         rsv_en
);

   localparam logic [ADDR_WIDTH:0]   SIZE_L   = (ADDR_WIDTH+1)'(REG_FILE_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_FILE_SIZE-1);

   // Addresses that exist and are not the hardwired zero register.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} < SIZE_L) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         CLEAR: begin
            busy  = 1'b1;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
               flush   = 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign dbg_state = state_q;

   logic [ADDR_WIDTH-1:0]    wa [NUM_WR];
   logic [DATA_WIDTH-1:0]    wd [NUM_WR];
   logic [NUM_WR-1:0]        wr_ok;
   logic [REG_FILE_SIZE-1:0] wr_clr;
   logic                     rsv_ok;
   logic [NUM_RD-1:0]        sb_pend;

   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
      assign wa[j]    = reg_w_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[j]    = reg_w_data[j*DATA_WIDTH +: DATA_WIDTH];
      assign wr_ok[j] = !busy && reg_w_en[j] && addr_ok(wa[j]);
   end

   assign rsv_ok = !busy && rsv_en && addr_ok(rsv_addr);

   always_comb begin
      wr_clr = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_ok[j]) wr_clr[wa[j]] = 1'b1;
      end
   end

   logic [DATA_WIDTH-1:0] mem_q [REG_FILE_SIZE];
   logic [DATA_WIDTH-1:0] mem_d [REG_FILE_SIZE];

   // Ascending port loop lets the highest-index write to an entry win.
   always_comb begin
      mem_d = mem_q;
      if (busy) mem_d[idx_q] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_ok[j]) mem_d[wa[j]] = wd[j];
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   reg_file_scoreboard #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .REG_FILE_SIZE (REG_FILE_SIZE),
      .NUM_RD        (NUM_RD)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .rsv_en_i   (rsv_ok),
      .rsv_addr_i (rsv_addr),
      .wr_clr_i   (wr_clr),
      .lk_addr_i  (reg_r_addr),
      .lk_pend_o  (sb_pend)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rdata;
      logic                  rpend;
`ifdef REG_FILE_BYPASS_EN
      logic [MAX_WR_PORTS-1:0] hits;
      int                      sel;
`endif
      assign ra = reg_r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         rdata = '0;
         rpend = 1'b0;
`ifdef REG_FILE_BYPASS_EN
         hits  = '0;
         for (int j = 0; j < NUM_WR; j++) hits[j] = wr_ok[j] && (wa[j] == ra);
         sel   = prio_sel(hits);
`endif
         if (!busy && addr_ok(ra)) begin
            rdata = mem_q[ra];
            rpend = sb_pend[i];
`ifdef REG_FILE_BYPASS_EN
            if (sel >= 0) begin
               rdata = wd[sel];
               rpend = rsv_ok && (rsv_addr == ra);
            end
`endif
         end
      end

      assign reg_r_data[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
      assign reg_r_pend[i]                          = rpend;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Multi-port register file with scoreboard and sequential clear, the parametrised successor to the CPU's single-write register file. It provides NUM_RD combinational read ports and NUM_WR prioritised write ports, tracks per-register pending-write bits for hazard detection, and zeroes the array after reset or on request. It sits between decode/issue (reads, reservations) and writeback (writes) in the CPU core.

## Interface
- ADDR_WIDTH, 4, register address width
- DATA_WIDTH, 16, register data width
- REG_FILE_SIZE, 16, number of entries (≤ 2**ADDR_WIDTH)
- NUM_RD, 2, read port count
- NUM_WR, 2, write port count
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/reservations

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clr_req  in  1  start sequential clear of array and scoreboard
- busy  out  1  clear in progress
- reg_r_addr  in  NUM_RD×ADDR_WIDTH  read addresses
- reg_r_data  out  NUM_RD×DATA_WIDTH  read data
- reg_r_pend  out  NUM_RD  pending bit of addressed register
- reg_w_addr  in  NUM_WR×ADDR_WIDTH  write addresses
- reg_w_data  in  NUM_WR×DATA_WIDTH  write data
- reg_w_en  in  NUM_WR  write enables; write also clears pending bit
- rsv_addr  in  ADDR_WIDTH  register to mark pending
- rsv_en  in  1  reservation strobe

## Operation
- Reads combinational: reg_r_data[i] = entry[reg_r_addr[i]]; address ≥ REG_FILE_SIZE → 0, pend 0.
- Writes on rising clk when reg_w_en[j]; same address on several ports → highest index j wins.
- Scoreboard: rsv_en sets pend[rsv_addr]; any write to an address clears its pend bit. Reservation and write to same address in same cycle → pend stays 1 (newer reservation wins); data still written.
- Clear FSM states: CLEAR, IDLE.
  - rst low → CLEAR, index 0, scoreboard all 0 (async).
  - CLEAR: writes 0 to entry[index] each cycle, index++; after entry REG_FILE_SIZE-1 → IDLE.
  - IDLE: clr_req → CLEAR, index 0, scoreboard cleared next edge.
  - clr_req in CLEAR ignored (no restart).
- During CLEAR: busy=1, external writes and reservations ignored, reg_r_data forced 0, reg_r_pend forced 0.
- ZERO_REG=1: entry 0 always reads 0, pend 0; writes/reservations to 0 dropped.
- Out-of-range write/reserve addresses dropped.

## Timing
- Reset values: busy=1, reg_r_data=0, reg_r_pend=0.
- Clear latency: busy high exactly REG_FILE_SIZE cycles after rst release or after the clr_req edge; IDLE on the following edge.
- Write visible on reads the cycle after the write edge (without bypass).
- Reservation visible on reg_r_pend the cycle after the rsv_en edge.
- rst asserted mid-clear or mid-write: array contents undefined until clear completes; FSM restarts at index 0.

## Configuration
- REG_FILE_BYPASS_EN defined: same-cycle forwarding; a read whose address matches an enabled write returns that write's data (highest-priority port) and reports pend=0 unless rsv_en targets the same address. Not applied during CLEAR.
- Undefined: reads return stored contents only; write visible one cycle later.

## Structure
- Package reg_file_pkg: clr_state_t enum (CLEAR, IDLE), default width constants, helper function for priority write-port select.
- Sub-module reg_file_scoreboard: pending-bit vector with reserve/clear/flush and NUM_RD lookups.

## Test plan
- Reset release, REG_FILE_SIZE=16 → busy high 16 cycles, then 0; all reads 0, pend 0.
- Write port 0 addr 3 data 0x1234 → read addr 3 returns 0x1234 next cycle (same cycle with REG_FILE_BYPASS_EN).
- Ports 0 and 1 both write addr 5 (0xAAAA, 0x5555) → addr 5 reads 0x5555.
- rsv_en addr 7 → pend 1 next cycle; write addr 7 with rsv_en addr 7 same cycle → pend stays 1; write alone → pend 0.
- Write addr 0 data 0xFFFF, ZERO_REG=1 → reads 0; writes during clr_req-triggered clear dropped, busy 16 cycles, all entries 0 after.
- rst asserted mid-clear at index 8 → busy stays 1, full 16-cycle clear restarts on release.
